// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed WIDTH x WIDTH multiplier using radix-2
// Booth recoding, one add/subtract-and-shift step per clock. Writes the
// 2*WIDTH-bit product into HI/LO and pulses done for one cycle when finished.
module booth_multiplier #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // Counter wide enough to hold the final step count itself.
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state_reg;

  // Datapath registers. The accumulator and multiplicand carry one extra bit
  // so that subtracting the most negative multiplicand cannot overflow.
  logic [WIDTH:0]   m_reg;
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_1_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Registered outputs.
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  // Next-step values for one Booth iteration.
  logic [1:0]       booth_pair;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q_next;
  logic             q_1_next;
  logic [CNT_W-1:0] cnt_next;
  logic             last_step;

  assign booth_pair = {q_reg[0], q_1_reg};

  // Booth recoding: 10 subtracts the multiplicand, 01 adds it, 00/11 keep.
  always_comb begin
    acc_sum = acc_reg;
    case (booth_pair)
      2'b10:   acc_sum = acc_reg - m_reg;
      2'b01:   acc_sum = acc_reg + m_reg;
      default: acc_sum = acc_reg;
    endcase
  end

  // Arithmetic right shift of {ACC, Q, q_1}: ACC sign bit is replicated,
  // the ACC LSB drops into the top of Q, and the Q LSB becomes the Booth bit.
  assign acc_next = {acc_sum[WIDTH], acc_sum[WIDTH:1]};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_q_shift
      assign q_next[gi] = q_reg[gi+1];
    end
  endgenerate
  assign q_next[WIDTH-1] = acc_sum[0];
  assign q_1_next        = q_reg[0];

  assign cnt_next  = cnt_reg + CNT_ONE;
  assign last_step = (cnt_next == LAST_CNT);

  // Control FSM and datapath; reset takes priority over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      q_1_reg   <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (MultCtrl) begin
            m_reg     <= {multiplicand[WIDTH-1], multiplicand};
            acc_reg   <= '0;
            q_reg     <= multiplier;
            q_1_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          q_reg   <= q_next;
          q_1_reg <= q_1_next;
          cnt_reg <= cnt_next;
          if (last_step) begin
            state_reg <= FINISH;
          end
        end
        FINISH: begin
          // Product is {ACC[WIDTH-1:0], Q}; both halves update together.
          hi_reg    <= acc_reg[WIDTH-1:0];
          lo_reg    <= q_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule
